// File: rtl/pipe_stage_chain.sv
// Elastic pipeline register chain: DEPTH valid/ready stages with bubble collapse and flush.
// Optional destination-hazard compare port built when PIPE_HAZARD_CHECK_EN is defined.

module pipe_stage_chain_chk #(
  parameter int DEPTH = 1,
  parameter int CNT_W = 1
) (
  input logic             clock,
  input logic             reset,
  input logic [DEPTH-1:0] valid_q,
  input logic [CNT_W-1:0] occupancy
);

  // the occupancy counter must always match the number of valid stages
  a_occ_popcount: assert property (@(posedge clock) disable iff (reset)
    occupancy == CNT_W'($countones(valid_q)));

endmodule

module pipe_stage_chain #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = $clog2(DEPTH + 1)
`ifdef PIPE_HAZARD_CHECK_EN
  ,
  parameter int ADRS_W   = 4,
  parameter int ADRS_LSB = 0,
  parameter int WEN_BIT  = DATA_W - 1
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  occupancy
`ifdef PIPE_HAZARD_CHECK_EN
  ,
  input  logic [ADRS_W-1:0] chk_adrs,
  output logic [DEPTH-1:0]  chk_hit,
  output logic              chk_any,
  output logic [DATA_W-1:0] chk_data
`endif
);

  logic [DEPTH-1:0]  valid_q;
  logic [DATA_W-1:0] data_q    [DEPTH];
  logic [DEPTH:0]    rdy;
  logic [DEPTH-1:0]  src_valid;
  logic [DATA_W-1:0] src_data  [DEPTH];
  logic              in_xfer;
  logic              out_xfer;

  // a stage is ready if it is empty or everything downstream of it can move
  always_comb begin
    logic acc;
    rdy      = '0;
    acc      = out_ready;
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc    = acc | ~valid_q[i];
      rdy[i] = acc;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_src
    if (g == 0) begin : g_head
      assign src_valid[g] = in_valid;
      assign src_data[g]  = in_data;
    end else begin : g_body
      assign src_valid[g] = valid_q[g-1];
      assign src_data[g]  = data_q[g-1];
    end
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // stage registers; data only moves when its source is valid to avoid needless toggling
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) begin
          valid_q[i] <= src_valid[i];
          if (src_valid[i]) begin
            data_q[i] <= src_data[i];
          end
        end
      end
    end
  end

  // occupancy tracks accepted minus delivered entries
  always_ff @(posedge clock) begin
    if (reset) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else begin
      occupancy <= occupancy + CNT_W'(in_xfer) - CNT_W'(out_xfer);
    end
  end

`ifdef PIPE_HAZARD_CHECK_EN
  // youngest (lowest-index) hitting stage wins the forwarded payload
  always_comb begin
    chk_hit  = '0;
    chk_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      chk_hit[i] = valid_q[i] & data_q[i][WEN_BIT] &
                   (data_q[i][ADRS_LSB +: ADRS_W] == chk_adrs);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      chk_data = chk_hit[i] ? data_q[i] : chk_data;
    end
  end

  assign chk_any = |chk_hit;
`endif

  pipe_stage_chain_chk #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_chk (
    .clock     (clock),
    .reset     (reset),
    .valid_q   (valid_q),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain (DATA_W=8, DEPTH=3); hazard port exercised when
// PIPE_HAZARD_CHECK_EN is defined.

module tb_pipe_stage_chain;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 3;
  localparam int CNT_W  = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  occupancy;
`ifdef PIPE_HAZARD_CHECK_EN
  logic [3:0]        chk_adrs;
  logic [DEPTH-1:0]  chk_hit;
  logic              chk_any;
  logic [DATA_W-1:0] chk_data;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] exp_q[$];

  always #5 clock = ~clock;

  pipe_stage_chain #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
`ifdef PIPE_HAZARD_CHECK_EN
    ,
    .ADRS_W   (4),
    .ADRS_LSB (0),
    .WEN_BIT  (7)
`endif
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_HAZARD_CHECK_EN
    ,
    .chk_adrs  (chk_adrs),
    .chk_hit   (chk_hit),
    .chk_any   (chk_any),
    .chk_data  (chk_data)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // scoreboard: handshakes seen mid-cycle complete at the next rising edge
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("sb_spurious_out", 32'(out_valid), 32'd0);
        end else begin
          check_val("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
      if (flush) begin
        exp_q.delete();
      end else if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
`ifdef PIPE_HAZARD_CHECK_EN
    chk_adrs  = 4'd0;
`endif
    step();
    step();
    reset = 1'b0;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_data", 32'(out_data), 32'd0);
    check_val("rst_occ", 32'(occupancy), 32'd0);
    @(negedge clock);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);

    // streaming with no backpressure: latency DEPTH-1 edges after acceptance
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    step();
    check_val("t1_lat_a", 32'(out_valid), 32'd0);
    in_data = 8'h22;
    step();
    check_val("t1_lat_b", 32'(out_valid), 32'd0);
    in_data = 8'h33;
    step();
    in_valid = 1'b0;
    check_val("t1_first_valid", 32'(out_valid), 32'd1);
    check_val("t1_first_data", 32'(out_data), 32'h11);
    check_val("t1_peak_occ", 32'(occupancy), 32'd3);
    step();
    check_val("t1_second_data", 32'(out_data), 32'h22);
    check_val("t1_second_occ", 32'(occupancy), 32'd2);
    step();
    check_val("t1_third_data", 32'(out_data), 32'h33);
    check_val("t1_third_occ", 32'(occupancy), 32'd1);
    step();
    check_val("t1_empty_valid", 32'(out_valid), 32'd0);
    check_val("t1_empty_occ", 32'(occupancy), 32'd0);

    // fill under backpressure, then release
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      in_data = 8'(k);
      step();
    end
    in_data = 8'h04;
    @(negedge clock);
    check_val("t2_full_in_ready", 32'(in_ready), 32'd0);
    check_val("t2_full_occ", 32'(occupancy), 32'd3);
    check_val("t2_stall_data", 32'(out_data), 32'h01);
    step();
    check_val("t2_hold_occ", 32'(occupancy), 32'd3);
    check_val("t2_hold_data", 32'(out_data), 32'h01);
    out_ready = 1'b1;
    @(negedge clock);
    check_val("t2_resume_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check_val("t2_after_data", 32'(out_data), 32'h02);
    check_val("t2_after_occ", 32'(occupancy), 32'd3);
    repeat (3) step();
    check_val("t2_drained_occ", 32'(occupancy), 32'd0);

    // bubble collapse
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hAA;
    step();
    in_valid = 1'b0;
    step();
    step();
    check_val("t3_aa_at_out", 32'(out_data), 32'hAA);
    in_valid = 1'b1;
    in_data  = 8'hBB;
    step();
    in_valid = 1'b0;
    step();
    check_val("t3_occ", 32'(occupancy), 32'd2);
    check_val("t3_head", 32'(out_data), 32'hAA);
    out_ready = 1'b1;
    step();
    check_val("t3_no_bubble", 32'(out_valid), 32'd1);
    check_val("t3_bb_data", 32'(out_data), 32'hBB);
    step();
    check_val("t3_empty", 32'(out_valid), 32'd0);

    // flush kills in-flight entries and the same-cycle input
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      in_data = 8'hC0 + 8'(k);
      step();
    end
    flush   = 1'b1;
    in_data = 8'hCC;
    @(negedge clock);
    check_val("t4_flush_in_ready", 32'(in_ready), 32'd0);
    check_val("t4_flush_out_valid", 32'(out_valid), 32'd1);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_val("t4_post_valid", 32'(out_valid), 32'd0);
    check_val("t4_post_occ", 32'(occupancy), 32'd0);
    out_ready = 1'b1;
    repeat (4) begin
      step();
      check_val("t4_no_cc", 32'(out_valid), 32'd0);
    end

    // reset mid-stream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hD1;
    step();
    in_data = 8'hD2;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check_val("t5_pre_occ", 32'(occupancy), 32'd2);
    out_ready = 1'b0;
    reset     = 1'b1;
    step();
    reset = 1'b0;
    check_val("t5_out_valid", 32'(out_valid), 32'd0);
    check_val("t5_out_data", 32'(out_data), 32'd0);
    check_val("t5_occ", 32'(occupancy), 32'd0);
    @(negedge clock);
    check_val("t5_in_ready", 32'(in_ready), 32'd1);

`ifdef PIPE_HAZARD_CHECK_EN
    // destination compare: youngest hit is forwarded
    in_valid = 1'b1;
    in_data  = 8'h95;
    step();
    in_data = 8'h85;
    step();
    in_valid = 1'b0;
    chk_adrs = 4'd5;
    #1;
    check_val("hz_hit", 32'(chk_hit), 32'h3);
    check_val("hz_any", 32'(chk_any), 32'd1);
    check_val("hz_data", 32'(chk_data), 32'h85);
    reset = 1'b1;
    step();
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h95;
    step();
    in_data = 8'h05;
    step();
    in_valid = 1'b0;
    #1;
    check_val("hz_wen_hit", 32'(chk_hit), 32'h2);
    check_val("hz_wen_any", 32'(chk_any), 32'd1);
    check_val("hz_wen_data", 32'(chk_data), 32'h95);
    chk_adrs = 4'd6;
    #1;
    check_val("hz_miss_any", 32'(chk_any), 32'd0);
    check_val("hz_miss_data", 32'(chk_data), 32'd0);
    out_ready = 1'b1;
    repeat (4) step();
`endif

    @(negedge clock);
    check_val("sb_left", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
